// File: rtl/eth_header_capture_if.sv
// Stream, parser-pulse and record-handshake bundle for eth_header_capture.
// The master side feeds bytes and pulses and accepts records; the slave side is the capture block.
interface eth_header_capture_if;
  logic        enable;
  logic [7:0]  data;
  logic        preamble_valid;
  logic        dst_addr_valid;
  logic        src_addr_valid;
  logic        type_length_valid;
  logic        frame_valid;
  logic        frame_ready;
  logic [47:0] dst_addr;
  logic [47:0] src_addr;
  logic [15:0] type_length;
  logic [10:0] payload_len;
  logic        len_sat;
  logic        drop_flag;
  logic        len_error;

  modport master (
    output enable, data, preamble_valid, dst_addr_valid, src_addr_valid,
           type_length_valid, frame_ready,
    input  frame_valid, dst_addr, src_addr, type_length, payload_len,
           len_sat, drop_flag, len_error
  );

  modport slave (
    input  enable, data, preamble_valid, dst_addr_valid, src_addr_valid,
           type_length_valid, frame_ready,
    output frame_valid, dst_addr, src_addr, type_length, payload_len,
           len_sat, drop_flag, len_error
  );
endinterface

// File: rtl/eth_header_capture.sv
// Captures Ethernet header fields and payload length into a single record with a valid/ready hand-off.
// Optional length check: define HDR_CAPTURE_LEN_CHECK_EN to compute len_error on record entry.
module eth_header_capture (
  input logic                 clock,
  input logic                 reset,
  eth_header_capture_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DST  = 3'd1,
    WAIT_SRC  = 3'd2,
    WAIT_TYPE = 3'd3,
    PAYLOAD   = 3'd4,
    PRESENT   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [47:0] window_r;
  logic        pre_prev_r;
  logic        dst_prev_r;
  logic        src_prev_r;
  logic        type_prev_r;
  logic        pre_rise_s;
  logic        dst_rise_s;
  logic        src_rise_s;
  logic        type_rise_s;
  logic        cap_dst_s;
  logic        cap_src_s;
  logic        cap_type_s;
  logic        clr_len_s;
  logic        cnt_en_s;
  logic        enter_present_s;
  logic        drop_set_s;
  logic        present_next_s;
  logic [47:0] dst_addr_r;
  logic [47:0] src_addr_r;
  logic [15:0] type_length_r;
  logic [10:0] payload_len_r;
  logic        len_sat_r;
  logic        drop_flag_r;
  logic        frame_valid_r;

  assign pre_rise_s  = bus.preamble_valid    & ~pre_prev_r;
  assign dst_rise_s  = bus.dst_addr_valid    & ~dst_prev_r;
  assign src_rise_s  = bus.src_addr_valid    & ~src_prev_r;
  assign type_rise_s = bus.type_length_valid & ~type_prev_r;

  // Byte window and previous-value copies of the parser pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      window_r    <= 48'd0;
      pre_prev_r  <= 1'b0;
      dst_prev_r  <= 1'b0;
      src_prev_r  <= 1'b0;
      type_prev_r <= 1'b0;
    end else begin
      if (bus.enable) begin
        window_r <= {window_r[39:0], bus.data};
      end
      pre_prev_r  <= bus.preamble_valid;
      dst_prev_r  <= bus.dst_addr_valid;
      src_prev_r  <= bus.src_addr_valid;
      type_prev_r <= bus.type_length_valid;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: preamble restart wins, then out-of-order fields, then end of frame
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pre_rise_s) state_next_s = WAIT_DST;
        else            state_next_s = IDLE;
      end
      WAIT_DST: begin
        if (pre_rise_s)                     state_next_s = WAIT_DST;
        else if (src_rise_s | type_rise_s)  state_next_s = IDLE;
        else if (!bus.enable)               state_next_s = IDLE;
        else if (dst_rise_s)                state_next_s = WAIT_SRC;
        else                                state_next_s = WAIT_DST;
      end
      WAIT_SRC: begin
        if (pre_rise_s)                     state_next_s = WAIT_DST;
        else if (dst_rise_s | type_rise_s)  state_next_s = IDLE;
        else if (!bus.enable)               state_next_s = IDLE;
        else if (src_rise_s)                state_next_s = WAIT_TYPE;
        else                                state_next_s = WAIT_SRC;
      end
      WAIT_TYPE: begin
        if (pre_rise_s)                     state_next_s = WAIT_DST;
        else if (dst_rise_s | src_rise_s)   state_next_s = IDLE;
        else if (!bus.enable)               state_next_s = IDLE;
        else if (type_rise_s)               state_next_s = PAYLOAD;
        else                                state_next_s = WAIT_TYPE;
      end
      PAYLOAD: begin
        if (pre_rise_s)                                  state_next_s = WAIT_DST;
        else if (dst_rise_s | src_rise_s | type_rise_s)  state_next_s = IDLE;
        else if (!bus.enable)                            state_next_s = PRESENT;
        else                                             state_next_s = PAYLOAD;
      end
      PRESENT: begin
        if (bus.frame_ready) state_next_s = pre_rise_s ? WAIT_DST : IDLE;
        else                 state_next_s = PRESENT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes derived from the chosen transition
  always_comb begin
    cap_dst_s       = (state_r == WAIT_DST)  && (state_next_s == WAIT_SRC);
    cap_src_s       = (state_r == WAIT_SRC)  && (state_next_s == WAIT_TYPE);
    cap_type_s      = (state_r == WAIT_TYPE) && (state_next_s == PAYLOAD);
    clr_len_s       = pre_rise_s && (state_next_s == WAIT_DST);
    cnt_en_s        = cap_type_s || ((state_r == PAYLOAD) && (state_next_s == PAYLOAD));
    enter_present_s = (state_r == PAYLOAD) && (state_next_s == PRESENT);
    drop_set_s      = (state_r == PRESENT) && pre_rise_s && !bus.frame_ready;
    present_next_s  = (state_next_s == PRESENT);
  end

  // Header field capture from the window as it stood before this edge
  always_ff @(posedge clock) begin
    if (reset) begin
      dst_addr_r    <= 48'd0;
      src_addr_r    <= 48'd0;
      type_length_r <= 16'd0;
    end else begin
      if (cap_dst_s)  dst_addr_r    <= window_r;
      if (cap_src_s)  src_addr_r    <= window_r;
      if (cap_type_s) type_length_r <= window_r[15:0];
    end
  end

  // Saturating payload counter
  always_ff @(posedge clock) begin
    if (reset) begin
      payload_len_r <= 11'd0;
      len_sat_r     <= 1'b0;
    end else if (clr_len_s) begin
      payload_len_r <= 11'd0;
      len_sat_r     <= 1'b0;
    end else if (cnt_en_s) begin
      if (payload_len_r == 11'd2047) begin
        len_sat_r <= 1'b1;
      end else begin
        payload_len_r <= payload_len_r + 11'd1;
        len_sat_r     <= (payload_len_r == 11'd2046);
      end
    end
  end

  // Record valid flag and sticky drop indicator
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_valid_r <= 1'b0;
      drop_flag_r   <= 1'b0;
    end else begin
      frame_valid_r <= present_next_s;
      if (drop_set_s) drop_flag_r <= 1'b1;
    end
  end

`ifdef HDR_CAPTURE_LEN_CHECK_EN
  logic len_error_r;

  // Length/type cross-check, only meaningful when type_length is a length (<= 1500)
  always_ff @(posedge clock) begin
    if (reset) begin
      len_error_r <= 1'b0;
    end else if (clr_len_s) begin
      len_error_r <= 1'b0;
    end else if (enter_present_s) begin
      len_error_r <= (type_length_r <= 16'd1500) && ({5'd0, payload_len_r} != type_length_r);
    end
  end

  assign bus.len_error = len_error_r;
`else
  logic unused_present_s;
  assign unused_present_s = enter_present_s;
  assign bus.len_error    = 1'b0;
`endif

  assign bus.frame_valid = frame_valid_r;
  assign bus.dst_addr    = dst_addr_r;
  assign bus.src_addr    = src_addr_r;
  assign bus.type_length = type_length_r;
  assign bus.payload_len = payload_len_r;
  assign bus.len_sat     = len_sat_r;
  assign bus.drop_flag   = drop_flag_r;

endmodule
